// File: rtl/hwag_sync_ctrl.sv
// HWAG sync sequencer: prime -> gap search -> verify -> synced.
// Owns tooth index, sync/loss events and saturating error count.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-low
//   ena_i        capture enable; low forces IDLE
//   edge_i       one-cycle strobe per filtered tooth edge
//   period_i     period ending at this edge (valid with edge_i)
//   gap_i        gap-search result (valid with edge_i)
//   ovf_i        period counter overflow (wheel stalled)
//   pmin_i       minimum legal period, inclusive
//   pmax_i       maximum legal period, inclusive
//   tooth_top_i  last tooth index before the gap
//   err_clr_i    strobe, clears err_cnt_o
//   state_o      FSM state code
//   synced_o     high while in SYNC
//   tooth_o      tooth index (0 outside VERIFY/SYNC)
//   sync_ev_o    pulse on entry to SYNC
//   lost_ev_o    pulse when SYNC is lost (not via ena/rst)
//   err_cnt_o    saturating error count
module hwag_sync_ctrl #(
   parameter int PW = 24,
   parameter int TW = 8,
   parameter int EW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          ena_i,
   input  logic          edge_i,
   input  logic [PW-1:0] period_i,
   input  logic          gap_i,
   input  logic          ovf_i,
   input  logic [PW-1:0] pmin_i,
   input  logic [PW-1:0] pmax_i,
   input  logic [TW-1:0] tooth_top_i,
   input  logic          err_clr_i,
   output logic [2:0]    state_o,
   output logic          synced_o,
   output logic [TW-1:0] tooth_o,
   output logic          sync_ev_o,
   output logic          lost_ev_o,
   output logic [EW-1:0] err_cnt_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRIME  = 3'd1,
      SEARCH = 3'd2,
      VERIFY = 3'd3,
      SYNC   = 3'd4,
      LOST   = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    good_q, good_d;
   logic [TW-1:0] tooth_q, tooth_d;
   logic [EW-1:0] err_q, err_d;
   logic          synced_q, synced_d;
   logic          sync_ev_q, sync_ev_d;
   logic          lost_ev_q, lost_ev_d;
   logic          err_inc;
   logic          ok;

   assign ok = (period_i >= pmin_i) && (period_i <= pmax_i);

   always_comb begin
      state_d   = state_q;
      good_d    = good_q;
      tooth_d   = tooth_q;
      sync_ev_d = 1'b0;
      lost_ev_d = 1'b0;
      err_inc   = 1'b0;
      if (!ena_i) begin
         state_d = IDLE;
         good_d  = '0;
         tooth_d = '0;
      end else if (ovf_i && state_q != IDLE) begin
         // stalled wheel: restart, concurrent edge ignored
         state_d   = PRIME;
         good_d    = '0;
         tooth_d   = '0;
         lost_ev_d = (state_q == SYNC);
      end else begin
         case (state_q)
            IDLE: begin
               state_d = PRIME;
               good_d  = '0;
               tooth_d = '0;
            end
            PRIME: begin
               if (edge_i) begin
                  if (!ok) begin
                     good_d = '0;
                  end else if (good_q == 2'd2) begin
                     state_d = SEARCH;
                     good_d  = '0;
                  end else begin
                     good_d = good_q + 2'd1;
                  end
               end
            end
            SEARCH: begin
               if (edge_i) begin
                  if (!ok) begin
                     state_d = PRIME;
                     good_d  = '0;
                  end else if (gap_i) begin
                     state_d = VERIFY;
                     tooth_d = '0;
                  end
               end
            end
            VERIFY, SYNC: begin
               if (edge_i) begin
                  if (!ok) begin
                     state_d   = PRIME;
                     good_d    = '0;
                     tooth_d   = '0;
                     err_inc   = 1'b1;
                     lost_ev_d = (state_q == SYNC);
                  end else if (gap_i && tooth_q == tooth_top_i) begin
                     state_d   = SYNC;
                     tooth_d   = '0;
                     sync_ev_d = (state_q == VERIFY);
                  end else if (!gap_i && tooth_q < tooth_top_i) begin
                     tooth_d = tooth_q + 1'b1;
                  end else begin
                     // early gap, missing gap, or index past a lowered top
                     err_inc = 1'b1;
                     tooth_d = '0;
                     if (state_q == VERIFY) begin
                        state_d = SEARCH;
                     end else begin
                        state_d   = LOST;
                        lost_ev_d = 1'b1;
                     end
                  end
               end
            end
            LOST: begin
               state_d = PRIME;
               good_d  = '0;
               tooth_d = '0;
            end
            default: begin
               state_d = IDLE;
               good_d  = '0;
               tooth_d = '0;
            end
         endcase
      end
      synced_d = (state_d == SYNC);
   end

   always_comb begin
      err_d = err_q;
      if (err_clr_i) begin
         err_d = '0;
      end else if (err_inc && err_q != '1) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         good_q    <= '0;
         tooth_q   <= '0;
         err_q     <= '0;
         synced_q  <= 1'b0;
         sync_ev_q <= 1'b0;
         lost_ev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         good_q    <= good_d;
         tooth_q   <= tooth_d;
         err_q     <= err_d;
         synced_q  <= synced_d;
         sync_ev_q <= sync_ev_d;
         lost_ev_q <= lost_ev_d;
      end
   end

   assign state_o   = state_q;
   assign synced_o  = synced_q;
   assign tooth_o   = tooth_q;
   assign sync_ev_o = sync_ev_q;
   assign lost_ev_o = lost_ev_q;
   assign err_cnt_o = err_q;

endmodule
